fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request port on behalf of the IFU. It issues one fetch at a time, waits a variable memory latency, and presents the instruction/PC pair to decode with a valid/ready handshake. It absorbs branch/jump redirects at any point, including while a fetch is in flight. It is the first stage of the multi-cycle and pipelined CPU variants and replaces the free-running PC register of the single-cycle IFU.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset; first fetch address.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- im_req  out  1  fetch request to instruction memory
- im_addr  out  32  fetch byte address
- im_gnt  in  1  memory accepts request this cycle (valid only with im_req)
- im_rvalid  in  1  read data valid, earliest one cycle after grant
- im_rdata  in  32  instruction word
- redirect  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  target address, valid with redirect
- id_ready  in  1  decode accepts instruction
- id_valid  out  1  instruction/PC pair valid
- id_instr  out  32  instruction word
- id_pc  out  32  address of id_instr
- exc_adel  out  1  misaligned fetch flag (see Configuration)

## Operation
- Registers: pc, inflight_pc, discard flag, state, id_* output registers.
- Fetch address fa = redirect ? redirect_pc : pc (combinational).
- IDLE (reset state): im_req=0; always -> REQ next cycle.
- REQ: im_req=1, im_addr=fa. On im_gnt: inflight_pc<=fa, discard<=0, -> WAIT. Without im_gnt: pc<=fa, stay REQ with im_addr held.
- WAIT: im_req=0. Priority order:
  - redirect with im_rvalid: drop data, pc<=redirect_pc, -> REQ.
  - redirect alone: pc<=redirect_pc, discard<=1, stay WAIT.
  - im_rvalid with discard=1: drop data, discard<=0, -> REQ.
  - im_rvalid with discard=0: id_instr<=im_rdata, id_pc<=inflight_pc, id_valid<=1, pc<=inflight_pc+4, -> HOLD.
- HOLD: id_valid=1; id_* stable. Priority order:
  - redirect: flush, id_valid<=0, pc<=redirect_pc, -> REQ. id_ready ignored; the held instruction is wrong-path.
  - id_ready: id_valid<=0, -> REQ.
  - otherwise stay.
- pc+4 wraps modulo 2^32.
- im_rvalid is ignored in IDLE, REQ and HOLD. This covers stale responses after a mid-fetch reset.

## Timing
- Reset values: im_req=0, im_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=RESET_PC, exc_adel=0, pc=RESET_PC, discard=0, state IDLE.
- Reset asserted mid-operation forces all of the above asynchronously. The first im_req comes one cycle after deassertion.
- Best case per instruction: REQ (1) + WAIT (1, rvalid the cycle after gnt) + HOLD (1, id_ready=1) = 3 cycles.
- There is no overlap; at most one outstanding memory request.
- id_valid rises the cycle after the accepted im_rvalid.
- im_addr and im_req are stable while im_req=1 and im_gnt=0, unless redirect arrives.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - In REQ, if fa[1:0]!=0, no request is issued (im_req=0).
  - Next cycle: HOLD with id_valid=1, id_instr=0, id_pc=fa, exc_adel=1, pc<=fa+4.
  - exc_adel clears when leaving HOLD.
- FETCH_ALIGN_CHECK_EN undefined:
  - exc_adel is tied 0.
  - im_addr[1:0] is forced to 2'b00; pc and id_pc carry the forced-aligned value.

## Test plan
- Reset release; gnt=1, rvalid one cycle after gnt, id_ready=1 -> im_req with im_addr 0x3000 one cycle after release. id_pc sequence 0x3000, 0x3004, 0x3008, with id_valid every 3rd cycle.
- id_ready=0 for 5 cycles while holding 0x3004 -> id_valid, id_pc, id_instr constant; im_req=0 throughout. Next im_addr after release is 0x3008.
- im_gnt withheld 3 cycles in REQ -> im_req=1 and im_addr=0x3008 constant for 4 cycles until grant.
- redirect to 0x3100 while WAIT for 0x300c, rvalid 2 cycles later -> 0x300c never appears on id_pc; next im_addr=0x3100.
- redirect to 0x3200 in a REQ cycle with im_gnt=1 -> im_addr=0x3200 that cycle; id_pc=0x3200 next. Reset pulse during WAIT then late rvalid -> ignored, first request is 0x3000.
- Macro on, redirect 0x3102 -> no im_req; id_valid=1, exc_adel=1, id_instr=0, id_pc=0x3102. Macro off, same stimulus -> im_addr=0x3100, exc_adel=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time, hands instr/PC to decode.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        exc_adel
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [AW-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   pc, pc_d;
  logic [AW-1:0]   inflight_pc, inflight_pc_d;
  logic            discard, discard_d;
  logic            id_valid_d;
  logic [AW-1:0]   id_instr_d, id_pc_d;
  logic            exc_adel_d;
  logic [AW-1:0]   fa_raw, fa, rpc;

  // Redirect target and fetch address; without the trap, low bits are forced to zero
  always_comb begin
    fa_raw = redirect ? redirect_pc : pc;
`ifdef FETCH_ALIGN_CHECK_EN
    rpc = redirect_pc;
    fa  = fa_raw;
`else
    rpc = {redirect_pc[AW-1:2], 2'b00};
    fa  = {fa_raw[AW-1:2], 2'b00};
`endif
  end

`ifndef FETCH_ALIGN_CHECK_EN
  logic unused_lsb;
  assign unused_lsb = ^fa_raw[1:0];
`endif

  assign im_addr = fa;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      discard     <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= RESET_PC;
      exc_adel    <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      inflight_pc <= inflight_pc_d;
      discard     <= discard_d;
      id_valid    <= id_valid_d;
      id_instr    <= id_instr_d;
      id_pc       <= id_pc_d;
      exc_adel    <= exc_adel_d;
    end
  end

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    inflight_pc_d = inflight_pc;
    discard_d     = discard;
    id_valid_d    = id_valid;
    id_instr_d    = id_instr;
    id_pc_d       = id_pc;
    exc_adel_d    = exc_adel;
    im_req        = 1'b0;

    unique case (state)
      IDLE: state_d = REQ;

      REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (fa[1:0] != 2'b00) begin
          // Misaligned: skip memory, present a trap slot to decode
          state_d    = HOLD;
          id_valid_d = 1'b1;
          id_instr_d = '0;
          id_pc_d    = fa;
          exc_adel_d = 1'b1;
          pc_d       = fa + PC_STEP;
        end else
`endif
        begin
          im_req = 1'b1;
          if (im_gnt) begin
            inflight_pc_d = fa;
            discard_d     = 1'b0;
            state_d       = WAIT;
          end else begin
            pc_d = fa;
          end
        end
      end

      WAIT: begin
        if (redirect && im_rvalid) begin
          pc_d    = rpc;
          state_d = REQ;
        end else if (redirect) begin
          pc_d      = rpc;
          discard_d = 1'b1;
        end else if (im_rvalid && discard) begin
          discard_d = 1'b0;
          state_d   = REQ;
        end else if (im_rvalid) begin
          id_instr_d = im_rdata;
          id_pc_d    = inflight_pc;
          id_valid_d = 1'b1;
          pc_d       = inflight_pc + PC_STEP;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        // A redirect makes the held instruction wrong-path, so it wins over id_ready
        if (redirect) begin
          id_valid_d = 1'b0;
          exc_adel_d = 1'b0;
          pc_d       = rpc;
          state_d    = REQ;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          exc_adel_d = 1'b0;
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl: one record per cycle, inputs plus expected outputs.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        im_req, im_gnt, im_rvalid, redirect, id_ready, id_valid, exc_adel;
  logic [31:0] im_addr, im_rdata, redirect_pc, id_instr, id_pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .exc_adel(exc_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pre_rst;
    bit          gnt, rv;
    logic [31:0] rdata;
    bit          rdr;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req, chk_addr;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc, e_instr;
    bit          e_exc;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] I0 = 32'hC0DE_0000, I1 = 32'hC0DE_0001, I2 = 32'hC0DE_0002;
  localparam logic [31:0] I3 = 32'hC0DE_0003, I4 = 32'hC0DE_0004, I5 = 32'hC0DE_0005;
  localparam logic [31:0] I6 = 32'hC0DE_0006, I7 = 32'hC0DE_0007, I8 = 32'hC0DE_0008;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] PP = 32'h0000_3500;
`else
  localparam logic [31:0] PP = 32'h0000_3100;
`endif

  function automatic vec_t v(bit pre_rst, bit gnt, bit rv, logic [31:0] rdata, bit rdr,
                             logic [31:0] rpc, bit rdy, bit e_req, bit chk_addr,
                             logic [31:0] e_addr, bit e_valid, logic [31:0] e_pc,
                             logic [31:0] e_instr, bit e_exc);
    vec_t r;
    r.pre_rst = pre_rst; r.gnt = gnt; r.rv = rv; r.rdata = rdata; r.rdr = rdr;
    r.rpc = rpc; r.rdy = rdy; r.e_req = e_req; r.chk_addr = chk_addr; r.e_addr = e_addr;
    r.e_valid = e_valid; r.e_pc = e_pc; r.e_instr = e_instr; r.e_exc = e_exc;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    im_gnt = x.gnt; im_rvalid = x.rv; im_rdata = x.rdata;
    redirect = x.rdr; redirect_pc = x.rpc; id_ready = x.rdy;
  endtask

  task automatic check_reset(input int idx);
    n_tests++;
    if (im_req !== 1'b0 || im_addr !== 32'h3000 || id_valid !== 1'b0 ||
        id_instr !== 32'h0 || id_pc !== 32'h3000 || exc_adel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state@%0d: req=%b addr=%h valid=%b instr=%h pc=%h exc=%b, required 0/00003000/0/00000000/00003000/0",
               idx, im_req, im_addr, id_valid, id_instr, id_pc, exc_adel);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t x);
    n_tests++;
    if (im_req !== x.e_req || (x.chk_addr && im_addr !== x.e_addr) ||
        id_valid !== x.e_valid || id_pc !== x.e_pc || id_instr !== x.e_instr ||
        exc_adel !== x.e_exc) begin
      n_fail++;
      $display("FAIL vec%0d: req=%b addr=%h valid=%b pc=%h instr=%h exc=%b, required req=%b addr=%h(chk=%b) valid=%b pc=%h instr=%h exc=%b",
               idx, im_req, im_addr, id_valid, id_pc, id_instr, exc_adel,
               x.e_req, x.e_addr, x.chk_addr, x.e_valid, x.e_pc, x.e_instr, x.e_exc);
    end
  endtask

  initial begin
    im_gnt = 0; im_rvalid = 0; im_rdata = 0; redirect = 0; redirect_pc = 0; id_ready = 0;

    // Back-to-back fetches, id_ready stall, grant stall
    vq.push_back(v(1, 0,0,0,   0,0,0,   0,1,32'h3000, 0,32'h3000,0,  0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3000, 0,32'h3000,0,  0));
    vq.push_back(v(0, 0,1,I0,  0,0,0,   0,0,0,        0,32'h3000,0,  0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3000,I0, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3004, 0,32'h3000,I0, 0));
    vq.push_back(v(0, 0,1,I1,  0,0,0,   0,0,0,        0,32'h3000,I0, 0));
    for (int k = 0; k < 5; k++)
      vq.push_back(v(0, 0,0,0, 0,0,0,   0,0,0,        1,32'h3004,I1, 0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3004,I1, 0));
    for (int k = 0; k < 3; k++)
      vq.push_back(v(0, 0,0,0, 0,0,0,   1,1,32'h3008, 0,32'h3004,I1, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3008, 0,32'h3004,I1, 0));
    vq.push_back(v(0, 0,1,I2,  0,0,0,   0,0,0,        0,32'h3004,I1, 0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3008,I2, 0));
    // Redirect during WAIT, response arrives two cycles later and is dropped
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h300c, 0,32'h3008,I2, 0));
    vq.push_back(v(0, 0,0,0,   1,32'h3100,0, 0,0,0,   0,32'h3008,I2, 0));
    vq.push_back(v(0, 0,0,0,   0,0,0,   0,0,0,        0,32'h3008,I2, 0));
    vq.push_back(v(0, 0,1,BAD, 0,0,0,   0,0,0,        0,32'h3008,I2, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3100, 0,32'h3008,I2, 0));
    vq.push_back(v(0, 0,1,I3,  0,0,0,   0,0,0,        0,32'h3008,I2, 0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3100,I3, 0));
    // Redirect in a granted REQ cycle; redirect flushes HOLD; redirect with rvalid
    vq.push_back(v(0, 1,0,0,   1,32'h3200,0, 1,1,32'h3200, 0,32'h3100,I3, 0));
    vq.push_back(v(0, 0,1,I4,  0,0,0,   0,0,0,        0,32'h3100,I3, 0));
    vq.push_back(v(0, 0,0,0,   1,32'h3300,1, 0,0,0,   1,32'h3200,I4, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3300, 0,32'h3200,I4, 0));
    vq.push_back(v(0, 0,1,BAD, 1,32'h3400,0, 0,0,0,   0,32'h3200,I4, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3400, 0,32'h3200,I4, 0));
    vq.push_back(v(0, 0,1,I5,  0,0,0,   0,0,0,        0,32'h3200,I4, 0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3400,I5, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3404, 0,32'h3400,I5, 0));
    vq.push_back(v(0, 0,0,0,   0,0,0,   0,0,0,        0,32'h3400,I5, 0));
    // Reset while in WAIT; stale rvalid in IDLE and ungranted REQ is ignored
    vq.push_back(v(1, 0,1,BAD, 0,0,0,   0,1,32'h3000, 0,32'h3000,0,  0));
    vq.push_back(v(0, 0,1,BAD, 0,0,0,   1,1,32'h3000, 0,32'h3000,0,  0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h3000, 0,32'h3000,0,  0));
    vq.push_back(v(0, 0,1,I6,  0,0,0,   0,0,0,        0,32'h3000,0,  0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3000,I6, 0));
`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect traps without a memory request
    vq.push_back(v(0, 1,0,0,   1,32'h3102,0, 0,0,0,   0,32'h3000,I6, 0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3102,0,  1));
    vq.push_back(v(0, 1,0,0,   1,32'h3500,0, 1,1,32'h3500, 0,32'h3102,0, 0));
    vq.push_back(v(0, 0,1,I7,  0,0,0,   0,0,0,        0,32'h3102,0,  0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3500,I7, 0));
`else
    // Misaligned redirect is forced to word alignment
    vq.push_back(v(0, 1,0,0,   1,32'h3102,0, 1,1,32'h3100, 0,32'h3000,I6, 0));
    vq.push_back(v(0, 0,1,I7,  0,0,0,   0,0,0,        0,32'h3000,I6, 0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'h3100,I7, 0));
`endif
    // PC wraps from 0xFFFF_FFFC to 0
    vq.push_back(v(0, 1,0,0,   1,32'hFFFF_FFFC,0, 1,1,32'hFFFF_FFFC, 0,PP,I7, 0));
    vq.push_back(v(0, 0,1,I8,  0,0,0,   0,0,0,        0,PP,I7,       0));
    vq.push_back(v(0, 0,0,0,   0,0,1,   0,0,0,        1,32'hFFFF_FFFC,I8, 0));
    vq.push_back(v(0, 1,0,0,   0,0,0,   1,1,32'h0,    0,32'hFFFF_FFFC,I8, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (vq[i].pre_rst) begin
        reset = 1'b1;
        im_gnt = 0; im_rvalid = 0; redirect = 0; id_ready = 0;
        #1 check_reset(i);
        @(negedge clk);
        reset = 1'b0;
      end
      drive(vq[i]);
      #1 check_vec(i, vq[i]);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
